// File: rtl/float_signed_to_kulisch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_signed_to_kulisch_pkg
// Description : Shared layouts and sizing helpers for the FloatSigned to
//               Kulisch accumulator conversion stage.
// Revision    : 1.0 - initial release
// ============================================================================
package float_signed_to_kulisch_pkg;

  // Default configuration of the log-domain MAC datapath.
  localparam int DEF_SIGNED_EXP   = 5;
  localparam int DEF_FRAC         = 8;
  localparam int DEF_ACC_NON_FRAC = 16;
  localparam int DEF_ACC_FRAC     = 16;
  localparam int DEF_W            = DEF_ACC_NON_FRAC + DEF_ACC_FRAC;

  // FloatSigned value: unbiased two's-complement exponent, hidden leading 1.
  typedef struct packed {
    logic                      sign;
    logic [DEF_SIGNED_EXP-1:0] exp;
    logic [DEF_FRAC-1:0]       frac;
    logic                      is_zero;
    logic                      is_inf;
  } float_signed_t;

  // Kulisch accumulator word plus its side flags.
  typedef struct packed {
    logic [DEF_W-1:0] data;
    logic             is_inf;
    logic             is_overflow;
    logic             overflow_sign;
  } kulisch_t;

  // Total accumulator width.
  function automatic int kulisch_width(input int acc_non_frac, input int acc_frac);
    return acc_non_frac + acc_frac;
  endfunction

  // Signed width able to hold the hidden-bit position, the shift derived
  // from it and the overflow threshold W-1 without wrapping.
  function automatic int pos_width(input int acc_frac, input int exp_w, input int w);
    return $clog2(acc_frac + (1 << (exp_w - 1)) + w + 1) + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/float_signed_to_kulisch_align_shift.sv
`default_nettype none
// ============================================================================
// Module      : kulisch_align_shift
// Description : Combinational bidirectional shifter placing the significand
//               at its hidden-bit position in the accumulator; also reports
//               when that position is at or beyond the accumulator sign bit.
// Revision    : 1.0 - initial release
// ============================================================================
module kulisch_align_shift #(
  parameter int FRAC = 8,
  parameter int W    = 32,
  parameter int PW   = 9
) (
  input  logic [FRAC:0]         sig,
  input  logic signed [PW-1:0]  pos,
  output logic [W-1:0]          mag,
  output logic                  overflow
);

  localparam logic signed [PW:0]   FRAC_S  = (PW+1)'(FRAC);
  localparam logic signed [PW-1:0] OVF_POS = PW'(W - 1);

  logic signed [PW:0] shift;
  logic [PW:0]        amt;
  logic [W-1:0]       sig_w;

  // Left shift when the LSB of sig lands at or above accumulator bit 0,
  // otherwise right shift and drop the bits that fall below it.
  always_comb begin
    sig_w    = W'(sig);
    shift    = {pos[PW-1], pos} - FRAC_S;
    amt      = shift[PW] ? -shift : shift;
    if (pos[PW-1]) begin
      mag = '0;
    end else if (shift[PW]) begin
      mag = sig_w >> amt;
    end else begin
      mag = sig_w << amt;
    end
    overflow = (pos >= OVF_POS);
  end

endmodule
`default_nettype wire

// File: rtl/float_signed_to_kulisch.sv
`default_nettype none
// ============================================================================
// Module      : float_signed_to_kulisch
// Description : Registered FloatSigned to Kulisch fixed-point converter.
//               Aligns, truncates toward zero, applies sign and flags
//               infinity / overflow. One cycle of latency, no backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module float_signed_to_kulisch
  import float_signed_to_kulisch_pkg::*;
#(
  parameter int SIGNED_EXP         = 5,
  parameter int FRAC               = 8,
  parameter int ACC_NON_FRAC       = 16,
  parameter int ACC_FRAC           = 16,
  parameter int OVERFLOW_DETECTION = 0,
  localparam int W                 = kulisch_width(ACC_NON_FRAC, ACC_FRAC)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_valid,
  input  logic                  in_sign,
  input  logic [SIGNED_EXP-1:0] in_exp,
  input  logic [FRAC-1:0]       in_frac,
  input  logic                  in_is_zero,
  input  logic                  in_is_inf,
  output logic                  out_valid,
  output logic [W-1:0]          out_data,
  output logic                  out_is_inf,
  output logic                  out_is_overflow,
  output logic                  out_overflow_sign
);

  localparam int                   PW         = pos_width(ACC_FRAC, SIGNED_EXP, W);
  localparam logic signed [PW-1:0] ACC_FRAC_P = PW'(ACC_FRAC);
  localparam logic                 OVF_EN     = (OVERFLOW_DETECTION != 0);

  logic signed [PW-1:0] pos;
  logic [FRAC:0]        sig;
  logic [W-1:0]         mag;
  logic                 overflow;
  logic                 ovf_flag;
  logic [W-1:0]         nxt_data;
  logic                 nxt_inf;
  logic                 nxt_ovf;
  logic                 nxt_ovf_sign;

  // Hidden-bit position in the accumulator and the full significand.
  always_comb begin
    pos = ACC_FRAC_P + {{(PW-SIGNED_EXP){in_exp[SIGNED_EXP-1]}}, in_exp};
    sig = {1'b1, in_frac};
  end

  kulisch_align_shift #(
    .FRAC (FRAC),
    .W    (W),
    .PW   (PW)
  ) u_align (
    .sig      (sig),
    .pos      (pos),
    .mag      (mag),
    .overflow (overflow)
  );

  assign ovf_flag = OVF_EN & overflow;

  // Sign application and special-case priority: inf, then zero, then overflow.
  always_comb begin
    nxt_data     = in_sign ? -mag : mag;
    nxt_inf      = 1'b0;
    nxt_ovf      = 1'b0;
    nxt_ovf_sign = 1'b0;
    if (in_is_inf) begin
      nxt_data = '0;
      nxt_inf  = 1'b1;
    end else if (in_is_zero) begin
      nxt_data = '0;
    end else if (ovf_flag) begin
      nxt_data     = '0;
      nxt_ovf      = 1'b1;
      nxt_ovf_sign = in_sign;
    end
  end

  // Output register stage, cleared asynchronously while resetn is low.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_is_inf        <= 1'b0;
      out_is_overflow   <= 1'b0;
      out_overflow_sign <= 1'b0;
    end else begin
      out_valid         <= in_valid;
      out_data          <= nxt_data;
      out_is_inf        <= nxt_inf;
      out_is_overflow   <= nxt_ovf;
      out_overflow_sign <= nxt_ovf_sign;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_signed_to_kulisch.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_signed_to_kulisch
// Description : Self-checking bench for float_signed_to_kulisch with three
//               configurations: wrap, overflow detection, ACC_FRAC=15.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_signed_to_kulisch;
  import float_signed_to_kulisch_pkg::*;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [7:0]  in_frac;
  logic        in_is_zero;
  logic        in_is_inf;

  logic        v0, v1, v2;
  logic [31:0] d0, d1;
  logic [30:0] d2;
  logic        inf0, inf1, inf2;
  logic        ovf0, ovf1, ovf2;
  logic        ovs0, ovs1, ovs2;

  int total = 0;
  int bad   = 0;
  kulisch_t prev0;

  always #5 clock = ~clock;

  float_signed_to_kulisch #(.OVERFLOW_DETECTION(0)) u_wrap (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_sign(in_sign),
    .in_exp(in_exp), .in_frac(in_frac), .in_is_zero(in_is_zero), .in_is_inf(in_is_inf),
    .out_valid(v0), .out_data(d0), .out_is_inf(inf0), .out_is_overflow(ovf0),
    .out_overflow_sign(ovs0));

  float_signed_to_kulisch #(.OVERFLOW_DETECTION(1)) u_ovf (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_sign(in_sign),
    .in_exp(in_exp), .in_frac(in_frac), .in_is_zero(in_is_zero), .in_is_inf(in_is_inf),
    .out_valid(v1), .out_data(d1), .out_is_inf(inf1), .out_is_overflow(ovf1),
    .out_overflow_sign(ovs1));

  float_signed_to_kulisch #(.ACC_FRAC(15), .OVERFLOW_DETECTION(0)) u_af15 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_sign(in_sign),
    .in_exp(in_exp), .in_frac(in_frac), .in_is_zero(in_is_zero), .in_is_inf(in_is_inf),
    .out_valid(v2), .out_data(d2), .out_is_inf(inf2), .out_is_overflow(ovf2),
    .out_overflow_sign(ovs2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, want);
    end
  endtask

  // Reference: value = (256+frac) * 2^(exp-8), scaled by 2^af, truncated.
  function automatic kulisch_t model(input float_signed_t f, input int af,
                                     input int w, input bit od);
    kulisch_t r;
    int       e2;
    longint   sigv, mag, sres;
    r = '0;
    if (f.is_inf) begin
      r.is_inf = 1'b1;
    end else if (!f.is_zero) begin
      e2   = int'($signed(f.exp)) + af - 8;
      sigv = 256 + longint'(f.frac);
      if (e2 >= 0) mag = sigv * (longint'(1) << e2);
      else         mag = sigv / (longint'(1) << (-e2));
      if (od && mag >= (longint'(1) << (w - 1))) begin
        r.is_overflow   = 1'b1;
        r.overflow_sign = f.sign;
      end else begin
        sres   = f.sign ? -mag : mag;
        r.data = 32'(sres & ((longint'(1) << w) - 1));
      end
    end
    return r;
  endfunction

  function automatic float_signed_t mk(input logic s, input int e, input logic [7:0] fr,
                                       input logic z, input logic i);
    float_signed_t f;
    f.sign = s; f.exp = 5'(e); f.frac = fr; f.is_zero = z; f.is_inf = i;
    return f;
  endfunction

  task automatic check_outs(input string tag, input logic v,
                            input kulisch_t e0, input kulisch_t e1, input kulisch_t e2);
    check({tag, ".valid0"}, 64'(v0), 64'(v));
    check({tag, ".data0"},  64'(d0), 64'(e0.data));
    check({tag, ".inf0"},   64'(inf0), 64'(e0.is_inf));
    check({tag, ".ovf0"},   64'(ovf0), 64'(e0.is_overflow));
    check({tag, ".ovs0"},   64'(ovs0), 64'(e0.overflow_sign));
    check({tag, ".valid1"}, 64'(v1), 64'(v));
    check({tag, ".data1"},  64'(d1), 64'(e1.data));
    check({tag, ".inf1"},   64'(inf1), 64'(e1.is_inf));
    check({tag, ".ovf1"},   64'(ovf1), 64'(e1.is_overflow));
    check({tag, ".ovs1"},   64'(ovs1), 64'(e1.overflow_sign));
    check({tag, ".valid2"}, 64'(v2), 64'(v));
    check({tag, ".data2"},  64'(d2), 64'(e2.data));
    check({tag, ".inf2"},   64'(inf2), 64'(e2.is_inf));
    check({tag, ".ovf2"},   64'(ovf2), 64'(e2.is_overflow));
    check({tag, ".ovs2"},   64'(ovs2), 64'(e2.overflow_sign));
  endtask

  task automatic drive(input float_signed_t f, input logic v);
    in_valid   = v;
    in_sign    = f.sign;
    in_exp     = f.exp;
    in_frac    = f.frac;
    in_is_zero = f.is_zero;
    in_is_inf  = f.is_inf;
  endtask

  // Drive on the falling edge, confirm the output has not moved yet, then
  // check the registered result just after the next rising edge.
  task automatic step(input string tag, input float_signed_t f, input logic v);
    kulisch_t e0, e1, e2;
    @(negedge clock);
    drive(f, v);
    #1;
    check({tag, ".hold"}, 64'(d0), 64'(prev0.data));
    @(posedge clock);
    #1;
    e0 = model(f, 16, 32, 1'b0);
    e1 = model(f, 16, 32, 1'b1);
    e2 = model(f, 15, 31, 1'b0);
    check_outs(tag, v, e0, e1, e2);
    prev0 = e0;
  endtask

  float_signed_t f;
  kulisch_t      zk;

  initial begin
    zk    = '0;
    prev0 = '0;
    resetn = 1'b0;
    drive(mk(1'b1, 3, 8'h55, 1'b0, 1'b0), 1'b1);

    // Reset holds everything at zero even with valid inputs present.
    repeat (2) @(posedge clock);
    #1;
    check_outs("reset", 1'b0, zk, zk, zk);

    @(negedge clock);
    drive(mk(1'b0, 0, 8'h00, 1'b0, 1'b0), 1'b0);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("release.valid0", 64'(v0), 64'd0);
    prev0 = model(mk(1'b0, 0, 8'h00, 1'b0, 1'b0), 16, 32, 1'b0);

    // Directed anchors from the conversion rules.
    step("one",      mk(1'b0,   0, 8'h00, 1'b0, 1'b0), 1'b1);
    check("one.const", 64'(d0), 64'h0001_0000);
    step("p75",      mk(1'b0,  -1, 8'h80, 1'b0, 1'b0), 1'b1);
    check("p75.const", 64'(d0), 64'h0000_C000);
    step("n75",      mk(1'b1,  -1, 8'h80, 1'b0, 1'b0), 1'b1);
    check("n75.const", 64'(d0), 64'hFFFF_4000);
    step("ulp",      mk(1'b0, -16, 8'hFF, 1'b0, 1'b0), 1'b1);
    check("ulp.const", 64'(d0), 64'h0000_0001);
    check("ulp.af15",  64'(d2), 64'h0);
    step("nulp",     mk(1'b1, -16, 8'hFF, 1'b0, 1'b0), 1'b1);
    check("nulp.const", 64'(d0), 64'hFFFF_FFFF);
    step("big",      mk(1'b0,  14, 8'h00, 1'b0, 1'b0), 1'b1);
    check("big.const", 64'(d0), 64'h4000_0000);
    check("big.noovf", 64'(ovf1), 64'h0);
    step("ovf",      mk(1'b1,  15, 8'h00, 1'b0, 1'b0), 1'b1);
    check("ovf.wrap",  64'(d0), 64'h8000_0000);
    check("ovf.flag",  64'(ovf1), 64'h1);
    check("ovf.sign",  64'(ovs1), 64'h1);
    check("ovf.data",  64'(d1), 64'h0);
    step("inf",      mk(1'b0,   2, 8'h12, 1'b0, 1'b1), 1'b1);
    check("inf.const", 64'(inf0), 64'h1);
    step("zero",     mk(1'b0,   5, 8'hAA, 1'b1, 1'b0), 1'b0);
    check("zero.const", 64'(d0), 64'h0);
    step("infzero",  mk(1'b1,  15, 8'hAA, 1'b1, 1'b1), 1'b1);
    check("infzero.const", 64'(inf0), 64'h1);

    // Back-to-back random samples, valid every cycle.
    for (int i = 0; i < 100; i++) begin
      f = mk(1'($urandom), int'($urandom_range(0, 31)), 8'($urandom),
             1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
      step("b2b", f, 1'b1);
    end

    // Random samples with gaps in valid.
    for (int i = 0; i < 200; i++) begin
      f = mk(1'($urandom), int'($urandom_range(0, 31)), 8'($urandom),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      step("rnd", f, 1'($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset in the middle of a stream, between clock edges.
    @(negedge clock);
    drive(mk(1'b1, 4, 8'h3C, 1'b0, 1'b0), 1'b1);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check_outs("areset", 1'b0, zk, zk, zk);
    @(negedge clock);
    drive(mk(1'b0, 1, 8'h01, 1'b0, 1'b0), 1'b0);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("rerelease.valid0", 64'(v0), 64'd0);
    prev0 = model(mk(1'b0, 1, 8'h01, 1'b0, 1'b0), 16, 32, 1'b0);

    for (int i = 0; i < 50; i++) begin
      f = mk(1'($urandom), int'($urandom_range(0, 31)), 8'($urandom), 1'b0, 1'b0);
      step("post", f, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
